// File: rtl/avalon_pio_pkg.sv
// Shared register map and edge-type encodings for the Avalon-MM PIO family.
package avalon_pio_pkg;

  localparam logic [2:0] REG_DATA       = 3'd0;
  localparam logic [2:0] REG_IN         = 3'd1;
  localparam logic [2:0] REG_IRQ_MASK   = 3'd2;
  localparam logic [2:0] REG_EDGE_CAP   = 3'd3;
  localparam logic [2:0] REG_OUTSET     = 3'd4;
  localparam logic [2:0] REG_OUTCLR     = 3'd5;
  localparam logic [2:0] REG_BLINK_MASK = 3'd6;
  localparam logic [2:0] REG_BLINK_DIV  = 3'd7;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  localparam int unsigned BUS_W       = 32;
  localparam int unsigned BLINK_DIV_W = 24;

endpackage

// File: rtl/avalon_pio_gpio_edge_detect.sv
// Input synchroniser chain, one-cycle-delayed copy and edge-type selection.
module pio_edge_detect
  import avalon_pio_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] sync_in,
  output logic [DATA_W-1:0] edge_c
);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
  logic [DATA_W-1:0]                  prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Edge vector is valid for exactly the cycle sync_in differs from prev.
  always_comb begin
    edge_c = sync_in & ~prev;
    if (EDGE_TYPE == EDGE_FALL) begin
      edge_c = ~sync_in & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_c = sync_in ^ prev;
    end
  end

endmodule

// File: rtl/avalon_pio_gpio.sv
// Avalon-MM GPIO: output register with set/clear, synchronised inputs, edge capture, irq.
// Optional blink prescaler on addresses 6/7 when AVALON_PIO_GPIO_BLINK_EN is defined.
module avalon_pio_gpio
  import avalon_pio_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0,
  parameter int unsigned       EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [BUS_W-1:0]  writedata,
  output logic [BUS_W-1:0]  readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] clr_mask;
  logic [DATA_W-1:0] out_reg;
  logic [DATA_W-1:0] irq_mask;
  logic [DATA_W-1:0] edge_cap;
  logic [DATA_W-1:0] sync_in;
  logic [DATA_W-1:0] edge_vec;
  logic              unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[DATA_W-1:0];
  assign unused_wdata = &{1'b0, writedata};
  assign clr_mask     = (wr && address == REG_EDGE_CAP) ? wdata : '0;

  pio_edge_detect #(
    .DATA_W      (DATA_W),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_detect (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync_in (sync_in),
    .edge_c  (edge_vec)
  );

  // Capture is OR-ed in after the clear so a same-cycle edge survives W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= RESET_VAL;
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr) begin
        case (address)
          REG_DATA:     out_reg  <= wdata;
          REG_OUTSET:   out_reg  <= out_reg | wdata;
          REG_OUTCLR:   out_reg  <= out_reg & ~wdata;
          REG_IRQ_MASK: irq_mask <= wdata;
          default:      ;
        endcase
      end
      edge_cap <= (edge_cap & ~clr_mask) | edge_vec;
      irq      <= |(edge_cap & irq_mask);
    end
  end

`ifdef AVALON_PIO_GPIO_BLINK_EN
  logic [DATA_W-1:0]      blink_mask;
  logic [BLINK_DIV_W-1:0] blink_div;
  logic [BLINK_DIV_W-1:0] presc;
  logic                   phase;

  // Prescaler counts 0..blink_div inclusive; a divisor write restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask <= '0;
      blink_div  <= '0;
      presc      <= '0;
      phase      <= 1'b0;
    end else begin
      if (wr && address == REG_BLINK_MASK) begin
        blink_mask <= wdata;
      end
      if (wr && address == REG_BLINK_DIV) begin
        blink_div <= writedata[BLINK_DIV_W-1:0];
        presc     <= '0;
      end else if (presc == blink_div) begin
        presc <= '0;
        phase <= ~phase;
      end else begin
        presc <= presc + BLINK_DIV_W'(1);
      end
    end
  end

  assign out_port = out_reg ^ (blink_mask & {DATA_W{phase}});
`else
  assign out_port = out_reg;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA:       readdata = BUS_W'(out_reg);
      REG_IN:         readdata = BUS_W'(sync_in);
      REG_IRQ_MASK:   readdata = BUS_W'(irq_mask);
      REG_EDGE_CAP:   readdata = BUS_W'(edge_cap);
`ifdef AVALON_PIO_GPIO_BLINK_EN
      REG_BLINK_MASK: readdata = BUS_W'(blink_mask);
      REG_BLINK_DIV:  readdata = BUS_W'(blink_div);
`endif
      default:        readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// Directed plus randomized bench for avalon_pio_gpio (DATA_W=8, RESET_VAL=A5, rising edges).
module tb_avalon_pio_gpio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  avalon_pio_gpio #(
    .DATA_W      (8),
    .RESET_VAL   (8'hA5),
    .EDGE_TYPE   (0),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus write; returns at the falling edge after the write edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Zero-wait-state read sampled mid-cycle.
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0] rdv;
    logic [7:0]  exp_out, exp_cap, exp_mask, old_in, nv, c;
    logic [31:0] d;
    logic [7:0]  ph_val;
    logic [7:0]  rst_exp [8];

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;

    repeat (2) @(negedge clk);
    chk("rst_out_in_reset", 32'(out_port), 32'hA5);
    chk("rst_irq_in_reset", 32'(irq), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    rst_exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), rdv);
      chk($sformatf("rst_read_addr%0d", a), rdv, 32'(rst_exp[a]));
    end
`ifndef AVALON_PIO_GPIO_BLINK_EN
    rd(3'd6, rdv); chk("reserved6_read", rdv, 32'h0);
    rd(3'd7, rdv); chk("reserved7_read", rdv, 32'h0);
`endif

    // Output register atomics and truncation.
    wr(3'd0, 32'h0000_000F); chk("data_write", 32'(out_port), 32'h0F);
    wr(3'd4, 32'h0000_0030); chk("outset",     32'(out_port), 32'h3F);
    wr(3'd5, 32'h0000_0005); chk("outclr",     32'(out_port), 32'h3A);
    rd(3'd0, rdv);           chk("data_read",  rdv, 32'h3A);
    rd(3'd4, rdv);           chk("outset_reads_0", rdv, 32'h0);
    wr(3'd0, 32'hFFFF_FF00); chk("data_trunc", 32'(out_port), 32'h00);

    // Rising edge on bit 0, latency and irq.
    wr(3'd2, 32'h1);
    in_port = 8'h01;
    repeat (2) @(negedge clk);
    rd(3'd3, rdv); chk("cap_not_yet",  rdv, 32'h0);
    @(negedge clk);
    rd(3'd3, rdv); chk("cap_after_3",  rdv, 32'h1);
    chk("irq_lags_cap", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'h1);
    rd(3'd1, rdv); chk("in_read", rdv, 32'h1);
    wr(3'd3, 32'h1);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'h0);
    rd(3'd3, rdv); chk("cap_cleared", rdv, 32'h0);
    in_port = 8'h00;
    repeat (5) @(negedge clk);
    rd(3'd3, rdv); chk("fall_no_capture", rdv, 32'h0);
    chk("fall_no_irq", 32'(irq), 32'h0);

    // Same-cycle capture and W1C on bit 2: capture must win.
    in_port = 8'h04; repeat (4) @(negedge clk);
    in_port = 8'h00; repeat (4) @(negedge clk);
    rd(3'd3, rdv); chk("cap2_preset", rdv, 32'h4);
    in_port = 8'h04;
    repeat (2) @(negedge clk);
    address = 3'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd(3'd3, rdv); chk("cap_wins_w1c", rdv, 32'h4);
    wr(3'd3, 32'h4);
    rd(3'd3, rdv); chk("w1c_alone", rdv, 32'h0);

    // Randomized output ops against a simple value model.
    exp_out = 8'h00;
    for (int i = 0; i < 30; i++) begin
      d = $urandom;
      case ($urandom_range(0, 2))
        0: begin wr(3'd0, d); exp_out = d[7:0]; end
        1: begin wr(3'd4, d); exp_out = exp_out | d[7:0]; end
        default: begin wr(3'd5, d); exp_out = exp_out & ~d[7:0]; end
      endcase
      chk($sformatf("rand_out_%0d", i), 32'(out_port), 32'(exp_out));
    end

    // Randomized inputs: captured bits accumulate rising transitions.
    exp_cap  = 8'h00;
    exp_mask = 8'h00;
    old_in   = in_port;
    wr(3'd2, 32'h0);
    for (int i = 0; i < 25; i++) begin
      nv      = 8'($urandom);
      in_port = nv;
      exp_cap = exp_cap | (nv & ~old_in);
      old_in  = nv;
      repeat (4) @(negedge clk);
      rd(3'd3, rdv); chk($sformatf("rand_cap_%0d", i), rdv, 32'(exp_cap));
      rd(3'd1, rdv); chk($sformatf("rand_in_%0d", i), rdv, 32'(nv));
      chk($sformatf("rand_irq_%0d", i), 32'(irq), 32'(|(exp_cap & exp_mask)));
      exp_mask = 8'($urandom);
      wr(3'd2, 32'(exp_mask));
      c = 8'($urandom);
      wr(3'd3, 32'(c));
      exp_cap = exp_cap & ~c;
    end

    // Asynchronous reset mid-operation.
    wr(3'd0, 32'h12);
    wr(3'd2, 32'hFF);
    in_port = 8'h00; repeat (5) @(negedge clk);
    wr(3'd3, 32'hFF);
    in_port = 8'hFF; repeat (5) @(negedge clk);
    rd(3'd3, rdv); chk("pre_rst_cap", rdv, 32'hFF);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    chk("pre_rst_out", 32'(out_port), 32'h12);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_irq", 32'(irq), 32'h0);
    chk("async_rst_out", 32'(out_port), 32'hA5);
    rd(3'd3, rdv); chk("async_rst_cap", rdv, 32'h0);
    in_port = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out", 32'(out_port), 32'hA5);

`ifdef AVALON_PIO_GPIO_BLINK_EN
    // Blink: toggle period is BLINK_DIV+1 cycles; divisor write restarts count.
    wr(3'd0, 32'h00);
    wr(3'd6, 32'h03);
    wr(3'd7, 32'h04);
    rd(3'd6, rdv); chk("blink_mask_read", rdv, 32'h3);
    rd(3'd7, rdv); chk("blink_div_read",  rdv, 32'h4);
    wr(3'd7, 32'h04);
    ph_val = out_port;
    chk("blink_start_val", 32'(ph_val == 8'h00 || ph_val == 8'h03), 32'h1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("blink_k%0d", k), 32'(out_port),
          32'((((k / 5) % 2) == 1) ? (ph_val ^ 8'h03) : ph_val));
    end
    ph_val = (((12 / 5) % 2) == 1) ? (ph_val ^ 8'h03) : ph_val;
    wr(3'd7, 32'h04);
    ph_val = out_port;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("blink_restart_k%0d", k), 32'(out_port),
          32'((k >= 5) ? (ph_val ^ 8'h03) : ph_val));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_pio_gpio.md
Name: avalon_pio_gpio

Overview:
- Parametrised Avalon-MM slave PIO; successor to the team's single-bit output-port PIO.
- Provides a DATA_W-bit output register with atomic set/clear, plus a DATA_W-bit synchronised input port.
- Inputs have per-bit edge capture and a maskable interrupt.
- Sits on the Nios II control bus; drives game control lines (text enable, sprite select) and samples push-buttons.

Parameters:
- DATA_W, 8, width of out_port/in_port, 1..32.
- RESET_VAL, 0, reset value of the output register (DATA_W bits).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, input synchroniser depth, 2..3.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above DATA_W ignored
- readdata  out  32  read data; bits above DATA_W read 0
- in_port  in  DATA_W  asynchronous external inputs
- out_port  out  DATA_W  registered output lines
- irq  out  1  level interrupt, active-high

Behaviour:
- Reset (async, reset_n low): out_reg=RESET_VAL, irq_mask=0, edge_cap=0, synchroniser/previous flops=0; out_port=RESET_VAL, irq=0.
- Write occurs when chipselect && !write_n; takes effect at the next clk edge.
- Register map:
  - 0 DATA: R/W out_reg.
  - 1 IN: RO, synchronised input.
  - 2 IRQ_MASK: R/W.
  - 3 EDGE_CAP: read; write-1-to-clear.
  - 4 OUTSET: WO, out_reg |= wdata.
  - 5 OUTCLR: WO, out_reg &= ~wdata.
  - 6, 7: reserved; read 0, writes ignored (unless BLINK_EN).
- Reads: zero wait states; readdata is combinational from address and current register state. Write-only registers read 0.
- Input path:
  - in_port passes through a SYNC_STAGES flop chain to give sync_in.
  - A prev register holds sync_in delayed one cycle.
  - edge = rising (sync_in & ~prev), falling (~sync_in & prev) or any (sync_in ^ prev), per EDGE_TYPE.
  - Latency from an in_port change to an edge_cap bit being set: SYNC_STAGES+1 clk cycles.
- edge_cap next value = (edge_cap & ~clr_mask) | edge.
  - A capture and a W1C on the same bit in the same cycle: the capture wins, and the bit stays 1.
- irq = |(edge_cap & irq_mask), registered, so it lags edge_cap by 1 cycle. It stays high until the bit is cleared or masked.
- out_port is driven directly from the out_reg flop (plus the blink term, if enabled). A write is visible on out_port the cycle after the write edge.
- Write data is truncated to DATA_W bits; upper bits have no effect.

Optional Feature:
- Macro: AVALON_PIO_GPIO_BLINK_EN.
- When defined:
  - Address 6 is BLINK_MASK (R/W, reset 0).
  - Address 7 is BLINK_DIV (R/W, 24 bits, reset 0).
  - A 24-bit prescaler counts 0..BLINK_DIV and then wraps to 0. On each wrap, a phase flop toggles (reset 0).
  - out_port = out_reg ^ (BLINK_MASK & {DATA_W{phase}}).
  - A write to BLINK_DIV resets the prescaler to 0 and leaves phase unchanged.
  - BLINK_DIV=0 toggles phase every cycle.
- When undefined: no prescaler logic; addresses 6/7 are reserved; out_port = out_reg.

Decomposition:
- Shared package avalon_pio_pkg:
  - Register address localparams: REG_DATA, REG_IN, REG_IRQ_MASK, REG_EDGE_CAP, REG_OUTSET, REG_OUTCLR, REG_BLINK_MASK, REG_BLINK_DIV.
  - EDGE_RISE/EDGE_FALL/EDGE_ANY constants.
- One sub-module, pio_edge_detect: DATA_W-wide synchroniser chain, prev register and edge-type selection. Output is a single-cycle edge vector.

Test Plan:
- Reset with RESET_VAL=8'hA5: out_port=A5, irq=0, and reads of addresses 0..5 return 000000A5, 0, 0, 0, 0, 0.
- Output atomics: write DATA=0x0F, OUTSET=0x30, then OUTCLR=0x05. out_port reads 0F, then 3F, then 3A, each one cycle after its write. Writing 0xFFFFFF00 to DATA gives out_port=00.
- Edge capture and irq: set IRQ_MASK=0x01, then raise in_port[0]. edge_cap[0]=1 after 3 cycles and irq=1 one cycle later. Writing EDGE_CAP=0x01 drops irq within 2 cycles. A falling edge captures nothing when EDGE_TYPE=0.
- Simultaneous event: time a W1C of bit 2 on the same cycle that edge[2] fires. edge_cap[2] stays 1.
- Reset mid-operation: with edge_cap=0xFF and irq=1, pulse reset_n low asynchronously between clock edges. irq and out_port return to reset values immediately, without waiting for a clk edge.
- BLINK_EN: DATA=0x00, BLINK_MASK=0x03, BLINK_DIV=4. out_port toggles between 00 and 03 every 5 cycles. Rewriting BLINK_DIV restarts the count.
